// File: rtl/alu_mdu_ctrl.sv
// alu_mdu_ctrl: RV32I ALU control decoder plus iterative M-extension multiply/divide unit
module alu_mdu_ctrl #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      alu_op,
    input  logic [6:0]      funct7,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            in_valid,
    input  logic            flush,
    output logic [3:0]      alu_ctrl,
    output logic            illegal_op,
    output logic            in_ready,
    output logic [XLEN-1:0] md_result,
    output logic            md_valid,
    output logic            md_busy,
    output logic            stall
);
    localparam int CW = $clog2(XLEN);
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
    state_t state, state_nx;
    logic [3:0] base;
    logic [XLEN-1:0] hi, lo, mc, hi_nx, lo_nx, res_nx, spec_res, a_mag, b_mag;
    logic [XLEN:0] sum, trial;
    logic [2*XLEN-1:0] prod;
    logic [2:0] f3;
    logic [CW-1:0] cnt;
    logic neg_q, neg_r, md_req, accept, is_div, sa, sb, a_neg, b_neg, div0, ovf, special, last;
    always_comb begin
        case (funct3)
            3'b000: base = 4'b0010;
            3'b001: base = 4'b0100;
            3'b010: base = 4'b1000;
            3'b011: base = 4'b1001;
            3'b100: base = 4'b0011;
            3'b101: base = 4'b0101;
            3'b110: base = 4'b0001;
            default: base = 4'b0000;
        endcase
        alu_ctrl = 4'b1111;
        case (alu_op)
            2'b00: alu_ctrl = 4'b0010;
            2'b01: alu_ctrl = 4'b0110;
            2'b10: alu_ctrl = funct7 == 7'b0000000 ? base :
                              funct7 == 7'b0000001 ? 4'b1110 :
                              funct7 == 7'b0100000 && funct3 == 3'b000 ? 4'b0110 :
                              funct7 == 7'b0100000 && funct3 == 3'b101 ? 4'b0111 : 4'b1111;
            default: alu_ctrl = funct3 == 3'b001 ? (funct7 == 7'b0000000 ? base : 4'b1111) :
                                funct3 == 3'b101 ? (funct7 == 7'b0000000 ? 4'b0101 :
                                                    funct7 == 7'b0100000 ? 4'b0111 : 4'b1111) : base;
        endcase
    end
    assign illegal_op = alu_ctrl == 4'b1111;
    assign md_req     = in_valid & (alu_ctrl == 4'b1110);
    assign in_ready   = state == IDLE;
    assign md_busy    = state != IDLE;
    assign md_valid   = state == DONE;
    assign stall      = md_req & (state != DONE);
    assign accept     = md_req & in_ready & ~flush;
    // Operand signedness: MULH/MULHSU/DIV/REM treat op_a as signed; MULH/DIV/REM op_b too
    assign is_div   = funct3[2];
    assign sb       = (funct3 == 3'b001) | (funct3[2] & ~funct3[0]);
    assign sa       = sb | (funct3 == 3'b010);
    assign a_neg    = sa & op_a[XLEN-1];
    assign b_neg    = sb & op_b[XLEN-1];
    assign a_mag    = a_neg ? -op_a : op_a;
    assign b_mag    = b_neg ? -op_b : op_b;
    assign div0     = op_b == '0;
    assign ovf      = sb & funct3[2] & (op_a == {1'b1, {(XLEN-1){1'b0}}}) & (&op_b);
    assign special  = is_div & (div0 | ovf);
    assign spec_res = funct3[1] ? (div0 ? op_a : '0) : (div0 ? '1 : op_a);
    // hi/lo hold {partial product, multiplier} for MUL and {remainder, quotient} for DIV
    assign sum    = {1'b0, hi} + (lo[0] ? {1'b0, mc} : '0);
    assign trial  = {hi, lo[XLEN-1]} - {1'b0, mc};
    assign hi_nx  = state == MUL ? sum[XLEN:1] : trial[XLEN] ? {hi[XLEN-2:0], lo[XLEN-1]} : trial[XLEN-1:0];
    assign lo_nx  = state == MUL ? {sum[0], lo[XLEN-1:1]} : {lo[XLEN-2:0], ~trial[XLEN]};
    assign prod   = neg_q ? -{hi_nx, lo_nx} : {hi_nx, lo_nx};
    assign res_nx = state == MUL ? (f3 == 3'b000 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]) :
                    f3[1] ? (neg_r ? -hi_nx : hi_nx) : (neg_q ? -lo_nx : lo_nx);
    assign last   = cnt == CW'(XLEN-1);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     state_nx = accept ? (special ? DONE : is_div ? DIV : MUL) : IDLE;
            MUL, DIV: state_nx = last ? DONE : state;
            default:  state_nx = IDLE;
        endcase
        if (flush) state_nx = IDLE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi        <= '0;
            lo        <= '0;
            mc        <= '0;
            f3        <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            cnt       <= '0;
            md_result <= '0;
        end else if (accept) begin
            hi    <= '0;
            lo    <= is_div ? a_mag : b_mag;
            mc    <= is_div ? b_mag : a_mag;
            f3    <= funct3;
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
            cnt   <= '0;
            if (special) md_result <= spec_res;
        end else if ((state == MUL || state == DIV) && !flush) begin
            hi  <= hi_nx;
            lo  <= lo_nx;
            cnt <= cnt + 1'b1;
            if (last) md_result <= res_nx;
        end
    end
endmodule

// File: doc/alu_mdu_ctrl.md
# alu_mdu_ctrl

Parametrised successor to the single-cycle ALU control decoder for the RISC-V datapath. It decodes `alu_op`/`funct7`/`funct3` into the 4-bit ALU control code for the full RV32I ALU set. It also owns an iterative multiply/divide unit (M extension) behind a valid/ready handshake, stalling the datapath while a multi-cycle operation runs. It sits between the main control unit and the ALU/writeback result mux.

## Interface
Parameters:
- `XLEN`, 32, operand/result width (≥8, even).

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `alu_op` in 2: 00 load/store, 01 branch, 10 R-type, 11 I-type ALU.
- `funct7` in 7: instruction funct7.
- `funct3` in 3: instruction funct3.
- `op_a` in XLEN: rs1 value.
- `op_b` in XLEN: rs2 value.
- `in_valid` in 1: decode stage holds a valid instruction.
- `flush` in 1: synchronous abort of any M operation.
- `alu_ctrl` out 4: combinational ALU control code.
- `illegal_op` out 1: combinational, unsupported encoding.
- `in_ready` out 1: high when the MDU is idle.
- `md_result` out XLEN: registered M result.
- `md_valid` out 1: one-cycle result strobe.
- `md_busy` out 1: MDU not idle.
- `stall` out 1: hold the pipeline.

## Operation
- **`alu_ctrl` codes:** ADD 0010, SUB 0110, AND 0000, OR 0001, XOR 0011, SLL 0100, SRL 0101, SRA 0111, SLT 1000, SLTU 1001, MDU 1110, invalid 1111.
- **`alu_op` 00 / 01:** 00 → ADD and 01 → SUB, regardless of the funct fields.
- **`alu_op` 10, `funct7`=0000000:** funct3 000 ADD, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL, 110 OR, 111 AND.
- **`alu_op` 10, `funct7`=0100000:** only 000 → SUB and 101 → SRA are legal.
- **`alu_op` 10, `funct7`=0000001:** M operation, `alu_ctrl`=1110. funct3 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- **`alu_op` 11:** same funct3 map as `alu_op` 10, with funct7 ignored, except:
  - 001 requires `funct7`=0000000.
  - 101 selects SRL (`funct7`=0000000) or SRA (0100000).
  - No SUB.
- **Illegal encodings:** any other combination gives `alu_ctrl`=1111 and `illegal_op`=1; the FSM does not start.
- **`md_req`:** `in_valid` & M operation.
- **Accept:** `md_req` & `in_ready`. At accept, operand magnitudes, sign flags, op type and funct3 are latched; later changes on `op_a`/`op_b` are ignored.
- **FSM states:** IDLE, MUL, DIV, DONE.
  - IDLE→MUL when a multiply is accepted.
  - IDLE→DIV when a divide/remainder is accepted.
  - IDLE→DONE directly on special cases.
  - MUL/DIV→DONE after XLEN iterations.
  - DONE→IDLE always.
- **MUL:** radix-2 shift-add on unsigned magnitudes into a 2·XLEN product.
  - Signedness: MULH both operands signed, MULHSU `op_a` signed only, MULHU/MUL unsigned magnitudes with MUL taking the low half.
  - The product is negated if the result sign is negative.
  - MUL returns bits [XLEN-1:0]; the others return [2·XLEN-1:XLEN].
- **DIV:** restoring division on magnitudes.
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
- **Special cases (no iteration):**
  - Divisor 0: quotient all-ones, remainder = dividend.
  - Signed overflow (most-negative ÷ −1): quotient = dividend, remainder 0.
- **`flush`:** from any state, `flush` forces IDLE on the next edge; no `md_valid` is produced and the partial result is discarded. `flush` in IDLE has no effect.

## Timing
- **Reset values:** `rst_n` low immediately (asynchronously) forces IDLE, `md_result`=0, `md_valid`=0, `md_busy`=0, `in_ready`=1. This applies mid-operation as well; no result is produced.
- **`alu_ctrl`/`illegal_op`:** purely combinational; not affected by reset.
- **`in_ready`** = (state==IDLE).
- **`md_busy`** = (state≠IDLE).
- **`md_valid`** = (state==DONE); `md_result` is stable during DONE and holds its value afterwards until the next DONE.
- **`stall`** = `md_req` & state≠DONE. The pipeline advances on the DONE cycle, and the next instruction is evaluated in the following cycle (IDLE).
- **Latency:** accept edge = cycle 0.
  - Iterating ops: `md_valid` in cycle XLEN+1.
  - Special cases: `md_valid` in cycle 1.
- **Back-to-back M ops:** `stall` is low for exactly the one DONE cycle, then high again from the IDLE cycle.
- **Simultaneous `flush` and accept in IDLE:** `flush` wins; nothing starts.

## Test plan
- **Decode:**
  - (10, 0100000, 000) → 0110.
  - (10, 0000000, 111) → 0000.
  - (00, x, x) → 0010.
  - (01, x, x) → 0110.
  - (11, 0100000, 000) → 0010.
  - (10, 0100000, 110) → 1111 with `illegal_op`=1.
- **MUL (XLEN=32):**
  - MUL 0xFFFFFFFD×7 → 0xFFFFFFEB, `md_valid` in cycle 33, `stall` high cycles 0–32.
  - MULH of the same operands → 0xFFFFFFFF.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
- **DIV:**
  - DIV −7/2 → 0xFFFFFFFD.
  - REM −7/2 → 0xFFFFFFFF.
  - DIVU 7/2 → 3.
  - REMU 7/2 → 1.
- **Special cases, each with `md_valid` in cycle 1:**
  - DIVU 5/0 → 0xFFFFFFFF.
  - REM 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000.
  - REM of the same operands → 0.
- **Abort:**
  - `flush` in cycle 10 of a MUL → no `md_valid`; `in_ready`=1 in cycle 11.
  - `rst_n` low mid-DIV → `md_busy`=0 and `md_result`=0 without waiting for a clock edge.
- **Back-to-back:** two MULs presented consecutively → two `md_valid` pulses 34 cycles apart; `op_a` changed during busy does not affect the first result.
